lz_divider: RTL and testbench

- Multi-cycle signed/unsigned 32-bit divider serving DIV/DIVU. Sits directly downstream of the CPU's two leading-zero counter instances.
- Drives the magnitudes of dividend and divisor into the counters and consumes their 32-bit counts.
- Uses the counts to pre-align the divisor, so only the significant quotient bits are iterated.
- Results go to the HI/LO write path: remainder to HI, quotient to LO.

---
 rtl/lz_divider.sv | 149 ++++++++++++++
 tb/tb_lz_divider.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/lz_divider.sv
// lz_divider: multi-cycle 32-bit signed/unsigned divider for DIV/DIVU.
// Operand magnitudes are fed to two external leading-zero counters.
// Their counts pre-align the divisor, so only the significant quotient bits are iterated.
// Optional divide-by-zero flag output: define LZ_DIVIDER_DZ_FLAG_EN.
//
// state | meaning
// IDLE  | waiting for start; results held
// PREP  | lz counts valid; choose shortcut or aligned iteration
// ITER  | one restoring-division step per cycle, n steps
// FIX   | apply result signs, publish results, pulse done next cycle

module lz_divider #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] mag_a,
    output logic [WIDTH-1:0] mag_b,
    input  logic [WIDTH-1:0] lz_a,
    input  logic [WIDTH-1:0] lz_b,
`ifdef LZ_DIVIDER_DZ_FLAG_EN
    output logic             div_zero,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PREP = 2'd1,
        S_ITER = 2'd2,
        S_FIX  = 2'd3
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] dividend_q;
    logic             sign_q;
    logic             sign_r;
    logic             skip_fix;
    logic [5:0]       cnt;
    logic [WIDTH-1:0] d_work;
    logic [WIDTH-1:0] r_work;
    logic [WIDTH-1:0] q_work;

    logic [5:0]       lz_a6;
    logic [5:0]       lz_b6;
    logic [5:0]       shift;
    logic             unused_lz;

    // Counts never exceed 32, so only the low six bits carry information.
    assign lz_a6     = lz_a[5:0];
    assign lz_b6     = lz_b[5:0];
    assign shift     = lz_b6 - lz_a6;
    assign unused_lz = ^{lz_a[WIDTH-1:6], lz_b[WIDTH-1:6]};

    // Divider sequencer: operand capture, alignment, iteration and sign fix-up.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            quotient   <= '0;
            remainder  <= '0;
            mag_a      <= '0;
            mag_b      <= '0;
            dividend_q <= '0;
            sign_q     <= 1'b0;
            sign_r     <= 1'b0;
            skip_fix   <= 1'b0;
            cnt        <= '0;
            d_work     <= '0;
            r_work     <= '0;
            q_work     <= '0;
`ifdef LZ_DIVIDER_DZ_FLAG_EN
            div_zero   <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        dividend_q <= dividend;
                        mag_a      <= (is_signed && dividend[WIDTH-1]) ? -dividend : dividend;
                        mag_b      <= (is_signed && divisor[WIDTH-1])  ? -divisor  : divisor;
                        sign_q     <= is_signed && (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
                        sign_r     <= is_signed && dividend[WIDTH-1];
                        busy       <= 1'b1;
                        state      <= S_PREP;
`ifdef LZ_DIVIDER_DZ_FLAG_EN
                        div_zero   <= 1'b0;
`endif
                    end
                end
                S_PREP: begin
                    if (mag_b == '0) begin
                        // Divide by zero returns the raw dividend; no sign fix-up applies.
                        q_work   <= '1;
                        r_work   <= dividend_q;
                        skip_fix <= 1'b1;
                        state    <= S_FIX;
                    end else if (lz_b6 < lz_a6) begin
                        q_work   <= '0;
                        r_work   <= mag_a;
                        skip_fix <= 1'b0;
                        state    <= S_FIX;
                    end else begin
                        q_work   <= '0;
                        r_work   <= mag_a;
                        d_work   <= mag_b << shift;
                        cnt      <= shift + 6'd1;
                        skip_fix <= 1'b0;
                        state    <= S_ITER;
                    end
                end
                S_ITER: begin
                    if (r_work >= d_work) begin
                        r_work <= r_work - d_work;
                        q_work <= {q_work[WIDTH-2:0], 1'b1};
                    end else begin
                        q_work <= {q_work[WIDTH-2:0], 1'b0};
                    end
                    d_work <= d_work >> 1;
                    cnt    <= cnt - 6'd1;
                    if (cnt == 6'd1) begin
                        state <= S_FIX;
                    end
                end
                S_FIX: begin
                    quotient  <= (sign_q && !skip_fix) ? -q_work : q_work;
                    remainder <= (sign_r && !skip_fix) ? -r_work : r_work;
                    done      <= 1'b1;
                    busy      <= 1'b0;
                    state     <= S_IDLE;
`ifdef LZ_DIVIDER_DZ_FLAG_EN
                    div_zero  <= skip_fix;
`endif
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lz_divider.sv
// Directed bench for lz_divider; models the two leading-zero counters.
module tb_lz_divider;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        is_signed;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic [31:0] mag_a;
    logic [31:0] mag_b;
    logic [31:0] lz_a;
    logic [31:0] lz_b;
    logic        busy;
    logic        done;
    logic [31:0] quotient;
    logic [31:0] remainder;
`ifdef LZ_DIVIDER_DZ_FLAG_EN
    logic        div_zero;
`endif

    int errors = 0;
    int checks = 0;

    lz_divider #(.WIDTH(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .is_signed (is_signed),
        .dividend  (dividend),
        .divisor   (divisor),
        .mag_a     (mag_a),
        .mag_b     (mag_b),
        .lz_a      (lz_a),
        .lz_b      (lz_b),
`ifdef LZ_DIVIDER_DZ_FLAG_EN
        .div_zero  (div_zero),
`endif
        .busy      (busy),
        .done      (done),
        .quotient  (quotient),
        .remainder (remainder)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] clz(input logic [31:0] v);
        for (int i = 31; i >= 0; i--) begin
            if (v[i]) return 32'(31 - i);
        end
        return 32'd32;
    endfunction

    assign lz_a = clz(mag_a);
    assign lz_b = clz(mag_b);

    // Issues one operation and counts edges after the start edge until done.
    task automatic run_op(input logic sg, input logic [31:0] a, input logic [31:0] b,
                          output int lat);
        @(negedge clk);
        start = 1'b1; is_signed = sg; dividend = a; divisor = b;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 0;
        while (lat < 60) begin
            @(posedge clk); #1;
            lat++;
            if (done) break;
        end
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL timeout a=%h b=%h: done=%b after %0d cycles, required 1", a, b, done, lat);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; is_signed = 1'b0; dividend = '0; divisor = '0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({busy, done} !== 2'b00) begin
            errors++; $display("FAIL reset_flags: busy,done=%b required 00", {busy, done});
        end
        checks++;
        if ({quotient, remainder, mag_a, mag_b} !== 128'd0) begin
            errors++; $display("FAIL reset_data: q=%h r=%h ma=%h mb=%h required 0", quotient, remainder, mag_a, mag_b);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_divu_basic();
        int lat;
        // 100/7: lz 25 vs 29 -> n=5, latency 7
        run_op(1'b0, 32'd100, 32'd7, lat);
        checks++;
        if (quotient !== 32'd14 || remainder !== 32'd2) begin
            errors++; $display("FAIL divu_100_7: q=%0d r=%0d required 14 2", quotient, remainder);
        end
        checks++;
        if (lat !== 7) begin
            errors++; $display("FAIL divu_100_7_lat: %0d required 7", lat);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++; $display("FAIL divu_busy_at_done: busy=%b required 0", busy);
        end
    endtask

    task automatic test_div_signed();
        int lat;
        // -7/2: mag 7 (lz 29), 2 (lz 30) -> n=2, latency 4; q=-3 r=-1
        run_op(1'b1, 32'hFFFF_FFF9, 32'd2, lat);
        checks++;
        if (quotient !== 32'hFFFF_FFFD || remainder !== 32'hFFFF_FFFF) begin
            errors++; $display("FAIL div_m7_2: q=%h r=%h required fffffffd ffffffff", quotient, remainder);
        end
        checks++;
        if (lat !== 4) begin
            errors++; $display("FAIL div_m7_2_lat: %0d required 4", lat);
        end
        checks++;
        if (mag_a !== 32'd7 || mag_b !== 32'd2) begin
            errors++; $display("FAIL div_mags: ma=%h mb=%h required 7 2", mag_a, mag_b);
        end
    endtask

    task automatic test_shortcuts();
        int lat;
        run_op(1'b0, 32'd3, 32'd10, lat);
        checks++;
        if (quotient !== 32'd0 || remainder !== 32'd3 || lat !== 2) begin
            errors++; $display("FAIL divu_3_10: q=%0d r=%0d lat=%0d required 0 3 2", quotient, remainder, lat);
        end
        run_op(1'b0, 32'd0, 32'd5, lat);
        checks++;
        if (quotient !== 32'd0 || remainder !== 32'd0 || lat !== 2) begin
            errors++; $display("FAIL divu_0_5: q=%0d r=%0d lat=%0d required 0 0 2", quotient, remainder, lat);
        end
`ifdef LZ_DIVIDER_DZ_FLAG_EN
        checks++;
        if (div_zero !== 1'b0) begin
            errors++; $display("FAIL dz_clear: div_zero=%b required 0", div_zero);
        end
`endif
    endtask

    task automatic test_div_by_zero();
        int lat;
        run_op(1'b0, 32'h0000_1234, 32'd0, lat);
        checks++;
        if (quotient !== 32'hFFFF_FFFF || remainder !== 32'h0000_1234 || lat !== 2) begin
            errors++; $display("FAIL divu_by_zero: q=%h r=%h lat=%0d required ffffffff 00001234 2", quotient, remainder, lat);
        end
        // signed negative dividend by zero: raw dividend, no sign fix-up
        run_op(1'b1, 32'hFFFF_FF00, 32'd0, lat);
        checks++;
        if (quotient !== 32'hFFFF_FFFF || remainder !== 32'hFFFF_FF00) begin
            errors++; $display("FAIL div_by_zero_signed: q=%h r=%h required ffffffff ffffff00", quotient, remainder);
        end
`ifdef LZ_DIVIDER_DZ_FLAG_EN
        checks++;
        if (div_zero !== 1'b1) begin
            errors++; $display("FAIL dz_set: div_zero=%b required 1", div_zero);
        end
`endif
    endtask

    task automatic test_back_to_back();
        int lat;
        logic got;
        // 0x80000000 / -1: mag 0x80000000 (lz 0), 1 (lz 31) -> n=32, latency 34
        @(negedge clk);
        start = 1'b1; is_signed = 1'b1; dividend = 32'h8000_0000; divisor = 32'hFFFF_FFFF;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 0;
        got = 1'b0;
        while (lat < 60) begin
            if (lat == 10) begin
                start = 1'b1; is_signed = 1'b0; dividend = 32'd50; divisor = 32'd3;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            lat++;
            if (lat == 3) begin
                checks++;
                if (mag_a !== 32'h8000_0000 || mag_b !== 32'd1 || busy !== 1'b1) begin
                    errors++; $display("FAIL ovf_mags: ma=%h mb=%h busy=%b required 80000000 1 1", mag_a, mag_b, busy);
                end
            end
            if (done) begin
                got = 1'b1;
                break;
            end
        end
        start = 1'b0;
        checks++;
        if (got !== 1'b1 || lat !== 34) begin
            errors++; $display("FAIL ovf_lat: done=%b lat=%0d required 1 34", got, lat);
        end
        checks++;
        if (quotient !== 32'h8000_0000 || remainder !== 32'd0) begin
            errors++; $display("FAIL ovf_result: q=%h r=%h required 80000000 0", quotient, remainder);
        end
        // start in the done cycle is accepted
        start = 1'b1; is_signed = 1'b0; dividend = 32'd100; divisor = 32'd7;
        @(posedge clk); #1;
        start = 1'b0;
        checks++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            errors++; $display("FAIL b2b_accept: busy=%b done=%b required 1 0", busy, done);
        end
        lat = 0;
        while (lat < 60) begin
            @(posedge clk); #1;
            lat++;
            if (done) break;
        end
        checks++;
        if (done !== 1'b1 || lat !== 7 || quotient !== 32'd14 || remainder !== 32'd2) begin
            errors++; $display("FAIL b2b_result: done=%b lat=%0d q=%0d r=%0d required 1 7 14 2", done, lat, quotient, remainder);
        end
    endtask

    task automatic test_reset_mid_op();
        int lat;
        logic seen;
        @(negedge clk);
        start = 1'b1; is_signed = 1'b0; dividend = 32'd1000; divisor = 32'd3;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, done} !== 2'b00 || quotient !== 32'd0 || remainder !== 32'd0) begin
            errors++; $display("FAIL async_reset: busy=%b done=%b q=%h r=%h required 0 0 0 0", busy, done, quotient, remainder);
        end
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (done) seen = 1'b1;
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 15; i++) begin
            @(posedge clk); #1;
            if (done) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin
            errors++; $display("FAIL abort_no_done: done seen=%b required 0", seen);
        end
        // 1000/3: lz 22 vs 30 -> n=9, latency 11
        run_op(1'b0, 32'd1000, 32'd3, lat);
        checks++;
        if (quotient !== 32'd333 || remainder !== 32'd1 || lat !== 11) begin
            errors++; $display("FAIL divu_1000_3: q=%0d r=%0d lat=%0d required 333 1 11", quotient, remainder, lat);
        end
    endtask

    initial begin
        test_reset();
        test_divu_basic();
        test_div_signed();
        test_shortcuts();
        test_div_by_zero();
        test_back_to_back();
        test_reset_mid_op();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
